count_seq_ctrl: RTL and testbench
=================================

# count_seq_ctrl

Command-driven sequencer for the mod-10 up/down digit counter. Accepts step commands (direction plus step count) over a valid/ready handshake, then steps an embedded digit counter exactly that many times. It reports a done pulse and tracks digit wrap-around. It sits between control logic and the counter datapath, so the counter advances only on command instead of free-running every cycle.

## Interface
- LEN_W, 4: width of the command step count (max run 2^LEN_W−1 steps)
- MODULUS, 10: digit modulus; legal range 2..16; count range 0..MODULUS−1
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_dir  in  1  1 = count up, 0 = count down; sampled on accept
- cmd_len  in  LEN_W  number of steps; sampled on accept
- abort  in  1  synchronous abort of the running command
- busy  out  1  command in progress (state RUN or DONE)
- done  out  1  one-cycle pulse at command completion
- aborted  out  1  valid with done; 1 if the command ended by abort
- number  out  4  registered copy of the digit, one cycle behind the internal count
- zero  out  1  registered flag, 1 when the internal count was 0 on the previous edge
- wrap_cnt  out  8  wraps during the current or last command (see Configuration)

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch dir and len, and clear wrap_cnt and aborted.
  - If len == 0, go to DONE. Otherwise go to RUN with rem = len.
- RUN:
  - Each cycle, step the counter once in the latched direction and decrement rem.
  - When rem == 1 and a step occurs, go to DONE.
  - abort == 1 in RUN suppresses the step for that cycle, sets aborted, and goes to DONE.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Counter stepping:
  - Up: MODULUS−1 → 0 is a wrap. Otherwise +1.
  - Down: 0 → MODULUS−1 is a wrap. Otherwise −1.
  - The counter holds its value whenever it is not stepped. The count persists across commands.
- abort outside RUN is ignored. cmd_valid outside IDLE is not accepted (cmd_ready = 0).
- Reset values: state IDLE, count 0, number 0, zero 0, done 0, aborted 0, busy 0, wrap_cnt 0, rem 0. cmd_ready = 1 out of reset.
- Reset mid-RUN: everything returns to reset values immediately. Partial progress is discarded.

## Timing
- Accept at edge k: state becomes RUN at edge k. Count changes at edges k+1 … k+N for cmd_len = N.
- The state becomes DONE at edge k+N, so done is high during the cycle after edge k+N. The state returns to IDLE at edge k+N+1, and the next accept is possible at that edge or later.
- len == 0: done is high in the cycle after edge k. No count change.
- number and zero lag the internal count by one edge.
- busy is combinational from state.
- cmd_ready is combinational from state and never depends on cmd_valid.

## Configuration
- Macro COUNT_SEQ_WRAP_CNT_EN.
- Defined: wrap_cnt increments on every wrap step, saturates at 255, is cleared on command accept, and holds after done.
- Undefined: no wrap-counter register; wrap_cnt is tied to 0.

## Structure
- Shared package count_seq_pkg holds:
  - the state enum (IDLE/RUN/DONE)
  - MODULUS_DEFAULT = 10
  - WRAP_CNT_W = 8
- Sub-module cnt_digit (the count register with step-enable and direction, wrap detect, registered number and zero outputs), instantiated once.
- The FSM, rem counter and wrap counter live in count_seq_ctrl.

## Test plan
- Reset, then an up command of len 3: count becomes 1, 2, 3 at edges k+1..k+3. done is high in the cycle after edge k+3. number = 3 one cycle after that. wrap_cnt = 0.
- From count 8, an up command of len 4: the count sequence is 9, 0, 1, 2. wrap_cnt = 1 with the macro defined, 0 without. zero = 1 in the cycle after the count returns to 0.
- From count 1, a down command of len 3: the count sequence is 0, 9, 8. wrap_cnt = 1.
- len 0 command: no count change; done pulses in the cycle after the accept edge; aborted = 0.
- Up command of len 10 with abort asserted after 4 steps: count stops at start+4 (mod 10); done = 1 and aborted = 1 in the same cycle; cmd_ready returns to 1 the next cycle.
- rst_n low mid-RUN and cmd_valid held during busy: all outputs return to reset values asynchronously; no command is accepted while busy = 1.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the command-driven digit counter sequencer.
package count_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned MODULUS_DEFAULT = 10;
  localparam int unsigned WRAP_CNT_W      = 8;

endpackage

// File: rtl/cnt_digit.sv
// Mod-MODULUS up/down digit register: steps only when enabled, flags wraps,
// and provides registered number/zero outputs lagging the count by one edge.
module cnt_digit
  import count_seq_pkg::*;
#(
  parameter int unsigned MODULUS = MODULUS_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step_i,
  input  logic       dir_i,
  output logic       wrap_o,
  output logic [3:0] number_o,
  output logic       zero_o
);

  localparam logic [3:0] MAX = 4'(MODULUS - 1);

  logic [3:0] count_q, count_d;
  logic [3:0] number_q;
  logic       zero_q;

  always_comb begin
    count_d = count_q;
    wrap_o  = 1'b0;
    if (step_i) begin
      if (dir_i) begin
        if (count_q == MAX) begin
          count_d = '0;
          wrap_o  = 1'b1;
        end else begin
          count_d = count_q + 4'd1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MAX;
          wrap_o  = 1'b1;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      number_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      number_q <= count_q;
      zero_q   <= (count_q == '0);
    end
  end

  assign number_o = number_q;
  assign zero_o   = zero_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Command sequencer stepping a cnt_digit a requested number of times.
// Optional wrap counter enabled by macro COUNT_SEQ_WRAP_CNT_EN.
module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned MODULUS = MODULUS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_dir,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [3:0]            number,
  output logic                  zero,
  output logic [WRAP_CNT_W-1:0] wrap_cnt
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               aborted_q, aborted_d;
  logic               step;
  logic               accept;
  logic               wrap;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    aborted_d = aborted_q;
    step      = 1'b0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          accept    = 1'b1;
          dir_d     = cmd_dir;
          rem_d     = cmd_len;
          aborted_d = 1'b0;
          state_d   = (cmd_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // Abort takes priority and suppresses this cycle's step.
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = DONE;
        end else begin
          step  = 1'b1;
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      dir_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign aborted   = aborted_q;

  cnt_digit #(
    .MODULUS(MODULUS)
  ) u_digit (
    .clk      (clk),
    .rst_n    (rst_n),
    .step_i   (step),
    .dir_i    (dir_q),
    .wrap_o   (wrap),
    .number_o (number),
    .zero_o   (zero)
  );

`ifdef COUNT_SEQ_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    if (accept)                         wrap_cnt_d = '0;
    else if (wrap && wrap_cnt_q != '1)  wrap_cnt_d = wrap_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wrap_cnt_q <= '0;
    else        wrap_cnt_q <= wrap_cnt_d;
  end

  assign wrap_cnt = wrap_cnt_q;
`else
  logic wrap_unused;
  assign wrap_unused = wrap | accept;
  assign wrap_cnt    = '0;
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed self-checking bench for count_seq_ctrl (MODULUS 10, LEN_W 4).
module tb_count_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_dir;
  logic [3:0] cmd_len;
  logic       abort;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] number;
  logic       zero;
  logic [7:0] wrap_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

`ifdef COUNT_SEQ_WRAP_CNT_EN
  localparam logic [7:0] W1 = 8'd1;
`else
  localparam logic [7:0] W1 = 8'd0;
`endif

  always #5 clk = ~clk;

  count_seq_ctrl #(
    .LEN_W   (4),
    .MODULUS (10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_len   (cmd_len),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .number    (number),
    .zero      (zero),
    .wrap_cnt  (wrap_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command for one edge; returns just after the accept edge.
  task automatic issue(input logic dir, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Full command: checks step count to done, flags at done, final number.
  task automatic do_cmd(input string tag, input logic dir, input logic [3:0] len,
                        input logic [7:0] exp_wrap, input logic [3:0] exp_num);
    int unsigned n = 0;
    issue(dir, len);
    while (!done && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_cycles"}, n, {28'd0, len});
    chk({tag, "_aborted"}, aborted, 1'b0);
    chk({tag, "_wrap"}, wrap_cnt, exp_wrap);
    tick();
    chk({tag, "_done_clr"}, done, 1'b0);
    chk({tag, "_ready"}, cmd_ready, 1'b1);
    chk({tag, "_number"}, number, exp_num);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir   = 1'b0;
    cmd_len   = '0;
    abort     = 1'b0;
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_number", number, 4'd0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_wrap", wrap_cnt, 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Up 3 from 0, step by step
    issue(1'b1, 4'd3);
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready", cmd_ready, 1'b0);
    tick(); chk("t1_n1", number, 4'd0);
    tick(); chk("t1_n2", number, 4'd1);
    tick(); chk("t1_n3", number, 4'd2);
    chk("t1_done", done, 1'b1);
    chk("t1_wrap", wrap_cnt, 8'd0);
    tick();
    chk("t1_number", number, 4'd3);
    chk("t1_done_clr", done, 1'b0);
    chk("t1_busy_clr", busy, 1'b0);

    // 3 -> 8, then up 4: 9,0,1,2
    do_cmd("t2a", 1'b1, 4'd5, 8'd0, 4'd8);
    issue(1'b1, 4'd4);
    tick();                                   // count 9
    tick(); chk("t2_n9", number, 4'd9);       // count 0
    chk("t2_z0", zero, 1'b0);
    tick(); chk("t2_n0", number, 4'd0);       // count 1
    chk("t2_z1", zero, 1'b1);
    tick(); chk("t2_n1", number, 4'd1);       // count 2
    chk("t2_z2", zero, 1'b0);
    chk("t2_done", done, 1'b1);
    chk("t2_wrap", wrap_cnt, W1);
    tick();
    chk("t2_number", number, 4'd2);

    // 2 -> 1, then down 3: 0,9,8
    do_cmd("t3a", 1'b0, 4'd1, 8'd0, 4'd1);
    do_cmd("t3", 1'b0, 4'd3, W1, 4'd8);

    // Zero length: no count change, wrap_cnt cleared
    do_cmd("t4", 1'b1, 4'd0, 8'd0, 4'd8);

    // Up 10 from 8, abort after 4 steps: 9,0,1,2 then stop
    issue(1'b1, 4'd10);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_done", done, 1'b1);
    chk("t5_aborted", aborted, 1'b1);
    chk("t5_ready", cmd_ready, 1'b0);
    chk("t5_number", number, 4'd2);
    chk("t5_wrap", wrap_cnt, W1);
    tick();
    chk("t5_ready2", cmd_ready, 1'b1);
    chk("t5_hold", number, 4'd2);
    chk("t5_aborted_hold", aborted, 1'b1);

    // Abort in IDLE ignored
    abort = 1'b1;
    tick();
    chk("t5_idle_abort", busy, 1'b0);
    tick();
    chk("t5_idle_num", number, 4'd2);
    abort = 1'b0;

    // Down 5 from 2 with cmd_valid held while busy; reset after 3 steps (1,0,9)
    issue(1'b0, 4'd5);
    cmd_valid = 1'b1;
    cmd_dir   = 1'b1;
    cmd_len   = 4'd7;
    for (int i = 0; i < 3; i++) begin
      chk("t6_ready_busy", cmd_ready, 1'b0);
      tick();
    end
    chk("t6_number", number, 4'd0);
    chk("t6_wrap", wrap_cnt, W1);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_ready", cmd_ready, 1'b1);
    chk("t6_rst_number", number, 4'd0);
    chk("t6_rst_zero", zero, 1'b0);
    chk("t6_rst_wrap", wrap_cnt, 8'd0);
    chk("t6_rst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Count restarted from 0
    do_cmd("t7", 1'b1, 4'd2, 8'd0, 4'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
